instr_sequencer: RTL

//   Parametrised instruction player for the coprocessor top. Holds a writable

---
 rtl/instr_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Instruction player: writable DEPTH-entry program issued over valid/ready, single-step or run mode.
// Optional breakpoint/HALT support is enabled by defining INSTR_SEQ_BKPT_EN.
module instr_sequencer #(
  parameter int INSTR_W = 22,
  parameter int DEPTH   = 14,
  parameter int PTR_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               run,
  input  logic               loop_en,
  input  logic [PTR_W-1:0]   prog_len,
  input  logic               wr_en,
  input  logic [PTR_W-1:0]   wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
`ifdef INSTR_SEQ_BKPT_EN
  input  logic [PTR_W-1:0]   bkpt_addr,
  output logic               halted,
`endif
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [PTR_W-1:0]   ptr,
  output logic               done
);

  localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

`ifdef INSTR_SEQ_BKPT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE_ST = 2'd2, HALT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DONE_ST = 2'd2} state_t;
`endif

  state_t             state_r;
  logic [INSTR_W-1:0] mem_r [DEPTH];
  logic               step_meta_r, step_sync_r, step_prev_r;
  logic               step_pulse_s;
  logic [PTR_W:0]     len_s;
  logic               last_s;
  logic [PTR_W-1:0]   next_ptr_s;
  logic               wr_ok_s;

  // step synchroniser and rising-edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
      step_prev_r <= 1'b0;
    end else begin
      step_meta_r <= step;
      step_sync_r <= step_meta_r;
      step_prev_r <= step_sync_r;
    end
  end

  assign step_pulse_s = step_sync_r & ~step_prev_r;

  // effective program length; ptr at or past len-1 counts as the last entry
  always_comb begin
    len_s = DEPTH_L;
    if (prog_len == '0 || {1'b0, prog_len} > DEPTH_L) begin
      len_s = DEPTH_L;
    end else begin
      len_s = {1'b0, prog_len};
    end
  end

  assign last_s     = ({1'b0, ptr} + (PTR_W+1)'(1)) >= len_s;
  assign next_ptr_s = last_s ? '0 : ptr + PTR_W'(1);
  assign wr_ok_s    = (state_r == IDLE) && wr_en && ({1'b0, wr_addr} < DEPTH_L);

  // program memory write port (not reset)
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // sequencer FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr         <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
`ifdef INSTR_SEQ_BKPT_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (run) begin
`ifdef INSTR_SEQ_BKPT_EN
            if (ptr == bkpt_addr) begin
              state_r <= HALT;
              halted  <= 1'b1;
            end else begin
              state_r     <= ISSUE;
              instr_out   <= mem_r[ptr];
              instr_valid <= 1'b1;
            end
`else
            state_r     <= ISSUE;
            instr_out   <= mem_r[ptr];
            instr_valid <= 1'b1;
`endif
          end else if (step_pulse_s) begin
            state_r     <= ISSUE;
            instr_out   <= mem_r[ptr];
            instr_valid <= 1'b1;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            ptr <= next_ptr_s;
            if (!run) begin
              state_r     <= IDLE;
              instr_valid <= 1'b0;
            end else if (last_s && !loop_en) begin
              state_r     <= DONE_ST;
              instr_valid <= 1'b0;
              done        <= 1'b1;
            end
`ifdef INSTR_SEQ_BKPT_EN
            else if (next_ptr_s == bkpt_addr) begin
              state_r     <= HALT;
              instr_valid <= 1'b0;
              halted      <= 1'b1;
            end
`endif
            else begin
              instr_out <= mem_r[next_ptr_s];
            end
          end
        end
        DONE_ST: begin
          if (!run) begin
            state_r <= IDLE;
            done    <= 1'b0;
          end
        end
`ifdef INSTR_SEQ_BKPT_EN
        HALT: begin
          if (!run) begin
            state_r <= IDLE;
            halted  <= 1'b0;
          end else if (step_pulse_s) begin
            state_r     <= ISSUE;
            instr_out   <= mem_r[ptr];
            instr_valid <= 1'b1;
            halted      <= 1'b0;
          end
        end
`endif
        default: begin
          state_r     <= IDLE;
          instr_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule
